// File: rtl/NVM_pkg.sv
// Shared types and default constants for the clean-block FIFO.
package NVM_pkg;

  localparam int CF_BLK_ADDR_W = 10;
  localparam int CF_LOW_WM     = 2;
  localparam int CF_HIGH_WM    = 6;

  typedef logic [CF_BLK_ADDR_W-1:0] blk_addr_t;

  typedef enum logic [1:0] {
    CF_IDLE = 2'd0,
    CF_INIT = 2'd1,
    CF_RUN  = 2'd2
  } cfifo_state_t;

endpackage

// File: rtl/clean_blk_fifo.sv
// Ring buffer of clean (erased) block addresses fed by the GC controller and
// drained by the write allocator. One slot is kept empty, so capacity is
// 2**FIFO_SIZE_BIT_NUM-1. Full/empty are decided from the entry count.
// Optional feature macro: CLEAN_FIFO_LOWMARK_EN adds the min_clean output.
module clean_blk_fifo
  import NVM_pkg::*;
#(
  parameter int FIFO_SIZE_BIT_NUM = 4,
  parameter int BLK_ADDR_W        = CF_BLK_ADDR_W,
  parameter int INIT_NUM          = 15,
  parameter int BLK_BASE          = 0,
  parameter int LOW_WM            = CF_LOW_WM,
  parameter int HIGH_WM           = CF_HIGH_WM
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         initial_fifo,
  input  logic                         fifo_write_en,
  input  logic [BLK_ADDR_W-1:0]        wr_blk,
  input  logic                         alloc_req,
  output logic                         alloc_valid,
  output logic [BLK_ADDR_W-1:0]        alloc_blk,
  output logic                         ini_full,
  output logic [FIFO_SIZE_BIT_NUM-1:0] clean_num,
  output logic                         fifo_recover_en,
`ifdef CLEAN_FIFO_LOWMARK_EN
  output logic [FIFO_SIZE_BIT_NUM-1:0] min_clean,
`endif
  output logic                         overflow_err
);

  localparam int                         DEPTH        = 1 << FIFO_SIZE_BIT_NUM;
  localparam logic [FIFO_SIZE_BIT_NUM-1:0] LP_CAP       = FIFO_SIZE_BIT_NUM'(DEPTH - 1);
  localparam logic [FIFO_SIZE_BIT_NUM-1:0] LP_LOW_WM    = FIFO_SIZE_BIT_NUM'(LOW_WM);
  localparam logic [FIFO_SIZE_BIT_NUM-1:0] LP_HIGH_WM   = FIFO_SIZE_BIT_NUM'(HIGH_WM);
  localparam logic [FIFO_SIZE_BIT_NUM-1:0] LP_INIT_LAST = FIFO_SIZE_BIT_NUM'(INIT_NUM - 1);
  localparam logic                         LP_INIT_NONE = (INIT_NUM == 0);

  cfifo_state_t                   r_state;
  cfifo_state_t                   w_next_state;
  logic [FIFO_SIZE_BIT_NUM-1:0]   r_wr_ptr;
  logic [FIFO_SIZE_BIT_NUM-1:0]   r_rd_ptr;
  logic [FIFO_SIZE_BIT_NUM-1:0]   r_count;
  logic [FIFO_SIZE_BIT_NUM-1:0]   r_init_idx;
  logic                           r_ini_full;
  logic                           r_recover;
  logic                           r_ovf;
  logic [BLK_ADDR_W-1:0]          r_mem [DEPTH];

  logic                           w_run_active;
  logic                           w_full;
  logic                           w_pop;
  logic                           w_push;
  logic                           w_drop;
  logic                           w_init_wr;
  logic                           w_wr_en;
  logic [BLK_ADDR_W-1:0]          w_wr_data;

  // State register: IDLE after reset, then follows the next-state logic.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= CF_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: initial_fifo restarts the pool load from any state.
  always_comb begin
    w_next_state = r_state;
    if (initial_fifo) begin
      w_next_state = LP_INIT_NONE ? CF_RUN : CF_INIT;
    end else begin
      case (r_state)
        CF_IDLE: w_next_state = CF_IDLE;
        CF_INIT: w_next_state = (r_init_idx == LP_INIT_LAST) ? CF_RUN : CF_INIT;
        CF_RUN:  w_next_state = CF_RUN;
        default: w_next_state = CF_IDLE;
      endcase
    end
  end

  // Push/pop qualification; a pop frees a slot for a same-cycle push when full.
  always_comb begin
    w_run_active = (r_state == CF_RUN) && !initial_fifo;
    w_full       = (r_count == LP_CAP);
    w_pop        = w_run_active && alloc_req && (r_count != {FIFO_SIZE_BIT_NUM{1'b0}});
    w_push       = w_run_active && fifo_write_en && (!w_full || w_pop);
    w_drop       = w_run_active && fifo_write_en && w_full && !w_pop;
    w_init_wr    = (r_state == CF_INIT) && !initial_fifo;
    w_wr_en      = w_push || w_init_wr;
    if (w_init_wr) begin
      w_wr_data = BLK_ADDR_W'(BLK_BASE) + BLK_ADDR_W'(r_init_idx);
    end else begin
      w_wr_data = wr_blk;
    end
  end

  // Pointers, count, status flags and the hysteresis GC trigger.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= {FIFO_SIZE_BIT_NUM{1'b0}};
      r_rd_ptr   <= {FIFO_SIZE_BIT_NUM{1'b0}};
      r_count    <= {FIFO_SIZE_BIT_NUM{1'b0}};
      r_init_idx <= {FIFO_SIZE_BIT_NUM{1'b0}};
      r_ini_full <= 1'b0;
      r_recover  <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_ini_full <= (w_next_state == CF_RUN);
      if (initial_fifo) begin
        r_wr_ptr   <= {FIFO_SIZE_BIT_NUM{1'b0}};
        r_rd_ptr   <= {FIFO_SIZE_BIT_NUM{1'b0}};
        r_count    <= {FIFO_SIZE_BIT_NUM{1'b0}};
        r_init_idx <= {FIFO_SIZE_BIT_NUM{1'b0}};
        r_recover  <= 1'b0;
        r_ovf      <= 1'b0;
      end else begin
        if (w_wr_en) begin
          r_wr_ptr <= r_wr_ptr + {{(FIFO_SIZE_BIT_NUM-1){1'b0}}, 1'b1};
        end else begin
          r_wr_ptr <= r_wr_ptr;
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + {{(FIFO_SIZE_BIT_NUM-1){1'b0}}, 1'b1};
        end else begin
          r_rd_ptr <= r_rd_ptr;
        end
        if (w_init_wr) begin
          r_init_idx <= r_init_idx + {{(FIFO_SIZE_BIT_NUM-1){1'b0}}, 1'b1};
        end else begin
          r_init_idx <= r_init_idx;
        end
        case ({w_wr_en, w_pop})
          2'b10:   r_count <= r_count + {{(FIFO_SIZE_BIT_NUM-1){1'b0}}, 1'b1};
          2'b01:   r_count <= r_count - {{(FIFO_SIZE_BIT_NUM-1){1'b0}}, 1'b1};
          default: r_count <= r_count;
        endcase
        if (w_drop) begin
          r_ovf <= 1'b1;
        end else begin
          r_ovf <= r_ovf;
        end
        // Trigger decided from the count before this edge, so it lags by one.
        if (r_state == CF_RUN) begin
          if (r_count <= LP_LOW_WM) begin
            r_recover <= 1'b1;
          end else if (r_count >= LP_HIGH_WM) begin
            r_recover <= 1'b0;
          end else begin
            r_recover <= r_recover;
          end
        end else begin
          r_recover <= 1'b0;
        end
      end
    end
  end

  // Storage array: written by the init sequence or by accepted pushes.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= w_wr_data;
    end
  end

`ifdef CLEAN_FIFO_LOWMARK_EN
  logic [FIFO_SIZE_BIT_NUM-1:0] r_min_clean;
  logic                         w_enter_run;

  // Detect the cycle in which the block enters RUN from a (re)initialisation.
  always_comb begin
    w_enter_run = (w_next_state == CF_RUN) && ((r_state != CF_RUN) || initial_fifo);
  end

  // Low-water mark of the pool seen in RUN since the last init.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_min_clean <= {FIFO_SIZE_BIT_NUM{1'b0}};
    end else if (w_enter_run) begin
      r_min_clean <= FIFO_SIZE_BIT_NUM'(INIT_NUM);
    end else if ((r_state == CF_RUN) && (r_count < r_min_clean)) begin
      r_min_clean <= r_count;
    end else begin
      r_min_clean <= r_min_clean;
    end
  end

  assign min_clean = r_min_clean;
`endif

  assign alloc_valid     = (r_state == CF_RUN) && (r_count != {FIFO_SIZE_BIT_NUM{1'b0}});
  assign alloc_blk       = alloc_valid ? r_mem[r_rd_ptr] : {BLK_ADDR_W{1'b0}};
  assign ini_full        = r_ini_full;
  assign clean_num       = r_count;
  assign fifo_recover_en = r_recover;
  assign overflow_err    = r_ovf;

endmodule

// File: tb/tb_clean_blk_fifo.sv
// Directed testbench for clean_blk_fifo (default build, 15-entry pool).
module tb_clean_blk_fifo;

  logic       clk;
  logic       rst;
  logic       initial_fifo;
  logic       fifo_write_en;
  logic [9:0] wr_blk;
  logic       alloc_req;
  logic       alloc_valid;
  logic [9:0] alloc_blk;
  logic       ini_full;
  logic [3:0] clean_num;
  logic       fifo_recover_en;
  logic       overflow_err;
`ifdef CLEAN_FIFO_LOWMARK_EN
  logic [3:0] min_clean;
`endif

  int total = 0;
  int bad   = 0;
  logic [9:0] q[$];
  logic do_pop, do_push, m_pop, m_push;

  clean_blk_fifo dut (
    .clk             (clk),
    .rst             (rst),
    .initial_fifo    (initial_fifo),
    .fifo_write_en   (fifo_write_en),
    .wr_blk          (wr_blk),
    .alloc_req       (alloc_req),
    .alloc_valid     (alloc_valid),
    .alloc_blk       (alloc_blk),
    .ini_full        (ini_full),
    .clean_num       (clean_num),
    .fifo_recover_en (fifo_recover_en),
`ifdef CLEAN_FIFO_LOWMARK_EN
    .min_clean       (min_clean),
`endif
    .overflow_err    (overflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_valid"},   32'(alloc_valid),     32'd0);
    chk({tag, "_blk"},     32'(alloc_blk),       32'd0);
    chk({tag, "_inifull"}, 32'(ini_full),        32'd0);
    chk({tag, "_num"},     32'(clean_num),       32'd0);
    chk({tag, "_recover"}, 32'(fifo_recover_en), 32'd0);
    chk({tag, "_ovf"},     32'(overflow_err),    32'd0);
  endtask

  initial begin
    rst = 1'b1; initial_fifo = 1'b0; fifo_write_en = 1'b0; wr_blk = 10'd0; alloc_req = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk_reset_state("reset");

    // 1: init pulse at cycle 0, writes 0..14 in cycles 1..15
    initial_fifo = 1'b1;
    tick();
    initial_fifo = 1'b0;
    chk("init_c1_num", 32'(clean_num), 32'd0);
    chk("init_c1_valid", 32'(alloc_valid), 32'd0);
    for (int i = 0; i < 14; i++) tick();
    chk("init_c15_num", 32'(clean_num), 32'd14);
    chk("init_c15_inifull", 32'(ini_full), 32'd0);
    tick();
    chk("init_c16_inifull", 32'(ini_full), 32'd1);
    chk("init_c16_num", 32'(clean_num), 32'd15);
    chk("init_c16_blk", 32'(alloc_blk), 32'd0);
    chk("init_c16_valid", 32'(alloc_valid), 32'd1);
    chk("init_c16_recover", 32'(fifo_recover_en), 32'd0);

    // 2: pop 13 in order, then hysteresis on refill
    alloc_req = 1'b1;
    for (int i = 0; i < 13; i++) begin
      chk("pop_order", 32'(alloc_blk), 32'(i));
      tick();
    end
    alloc_req = 1'b0;
    chk("pop13_num", 32'(clean_num), 32'd2);
    chk("pop13_recover_lag", 32'(fifo_recover_en), 32'd0);
    chk("pop13_head", 32'(alloc_blk), 32'd13);
    tick();
    chk("recover_set", 32'(fifo_recover_en), 32'd1);
    fifo_write_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wr_blk = 10'(200 + k);
      tick();
      chk("refill_num", 32'(clean_num), 32'(3 + k));
      chk("recover_hold", 32'(fifo_recover_en), 32'd1);
    end
    fifo_write_en = 1'b0;
    tick();
    chk("recover_clear", 32'(fifo_recover_en), 32'd0);
    chk("num6", 32'(clean_num), 32'd6);

    // 3: fill to capacity, overflow drop, then push+pop while full
    fifo_write_en = 1'b1;
    for (int k = 0; k < 9; k++) begin
      wr_blk = 10'(300 + k);
      tick();
    end
    chk("full_num", 32'(clean_num), 32'd15);
    chk("full_ovf_clear", 32'(overflow_err), 32'd0);
    wr_blk = 10'd100;
    tick();
    chk("drop_num", 32'(clean_num), 32'd15);
    chk("drop_ovf", 32'(overflow_err), 32'd1);
    chk("drop_head", 32'(alloc_blk), 32'd13);
    wr_blk = 10'd400;
    alloc_req = 1'b1;
    tick();
    fifo_write_en = 1'b0;
    alloc_req = 1'b0;
    chk("fullpp_num", 32'(clean_num), 32'd15);
    chk("fullpp_head", 32'(alloc_blk), 32'd14);

    // 4: mixed traffic across pointer wrap against a queue model
    q = {10'd14, 10'd200, 10'd201, 10'd202, 10'd203, 10'd300, 10'd301, 10'd302,
         10'd303, 10'd304, 10'd305, 10'd306, 10'd307, 10'd308, 10'd400};
    for (int c = 0; c < 40; c++) begin
      do_pop  = (c < 12) ? 1'b1 : (c % 3 != 0);
      do_push = (c < 12) ? (c % 2 == 0) : (c % 4 != 3);
      alloc_req = do_pop;
      fifo_write_en = do_push;
      wr_blk = 10'(500 + c);
      chk("mix_valid", 32'(alloc_valid), 32'(q.size() != 0));
      if (q.size() != 0) chk("mix_head", 32'(alloc_blk), 32'(q[0]));
      m_pop  = do_pop && (q.size() != 0);
      m_push = do_push && ((q.size() < 15) || m_pop);
      if (m_pop) void'(q.pop_front());
      if (m_push) q.push_back(wr_blk);
      tick();
      chk("mix_num", 32'(clean_num), 32'(q.size()));
    end
    alloc_req = 1'b0;
    fifo_write_en = 1'b0;

    // 5: bring count to 7, then re-init mid-RUN
    for (int k = 0; k < 30; k++) begin
      if (q.size() > 7) begin
        alloc_req = 1'b1;
        void'(q.pop_front());
        tick();
      end else if (q.size() < 7) begin
        fifo_write_en = 1'b1;
        wr_blk = 10'(700 + k);
        q.push_back(wr_blk);
        tick();
      end
      alloc_req = 1'b0;
      fifo_write_en = 1'b0;
    end
    chk("pre_reinit_num", 32'(clean_num), 32'd7);
    chk("pre_reinit_ovf", 32'(overflow_err), 32'd1);
    chk("pre_reinit_head", 32'(alloc_blk), 32'(q[0]));
    initial_fifo = 1'b1;
    tick();
    initial_fifo = 1'b0;
    alloc_req = 1'b1;
    chk("reinit_num", 32'(clean_num), 32'd0);
    chk("reinit_inifull", 32'(ini_full), 32'd0);
    chk("reinit_ovf", 32'(overflow_err), 32'd0);
    chk("reinit_valid", 32'(alloc_valid), 32'd0);
    for (int i = 0; i < 14; i++) tick();
    chk("reinit_c15_num", 32'(clean_num), 32'd14);
    alloc_req = 1'b0;
    tick();
    chk("reinit_c16_num", 32'(clean_num), 32'd15);
    chk("reinit_c16_inifull", 32'(ini_full), 32'd1);
    alloc_req = 1'b1;
    for (int i = 0; i < 15; i++) begin
      chk("refill_order", 32'(alloc_blk), 32'(i));
      tick();
    end
    alloc_req = 1'b0;

    // 6: pop on empty, push into empty (no bypass), reset during INIT
    chk("empty_num", 32'(clean_num), 32'd0);
    alloc_req = 1'b1;
    tick();
    chk("empty_pop_num", 32'(clean_num), 32'd0);
    chk("empty_pop_valid", 32'(alloc_valid), 32'd0);
    fifo_write_en = 1'b1;
    wr_blk = 10'd55;
    tick();
    fifo_write_en = 1'b0;
    alloc_req = 1'b0;
    chk("nobypass_num", 32'(clean_num), 32'd1);
    chk("nobypass_valid", 32'(alloc_valid), 32'd1);
    chk("nobypass_blk", 32'(alloc_blk), 32'd55);
    initial_fifo = 1'b1;
    tick();
    initial_fifo = 1'b0;
    tick();
    tick();
    chk("rst_init_num", 32'(clean_num), 32'd2);
    rst = 1'b1;
    tick();
    chk_reset_state("rst_in_init");
    rst = 1'b0;
    tick();
    chk("rst_stays_idle", 32'(clean_num), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
